noc_turn_arbiter: RTL
=====================

# noc_turn_arbiter

Per-router scheduler generating the one-hot `X_turn` vectors consumed by the router's route logic. Each of the five output ports (N, S, E, W, L) owns a round-robin turn register naming the single input port allowed to drive it. The register rotates among requesting inputs after every served flit, skips idle inputs, and optionally steps past an owner stalled on a full port. It sits between the input-buffer route-compute stage (request source) and the route logic (turn consumer, `X_port_enable` source).

## Interface
- `TIMEOUT`, 15: cycles an owner may hold a turn while requesting and unserved before forced rotation; only used with `NOC_TURN_TIMEOUT_EN`.
- `clk`  in  1  router clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `N_req`, `S_req`, `E_req`, `W_req`, `L_req`  in  5 each  inputs currently requesting that output port. Bit encoding: [4]=N, [3]=S, [2]=E, [1]=W, [0]=L input.
- `N_port_enable`, `S_port_enable`, `E_port_enable`, `W_port_enable`, `L_port_enable`  in  1 each  flit forwarded to that output this cycle (from route logic).
- `N_turn`, `S_turn`, `E_turn`, `W_turn`, `L_turn`  out  5 each  registered one-hot owner of that output, same encoding as `X_req`.

## Operation
- Requests are ANDed with a static legal-turn mask per output (Y-then-X routing). N out: S, L. S out: N, L. E out: N, S, W, L. W out: N, S, E, L. L out: N, S, E, W. Masked bits never influence state.
- Cyclic search order: N→S→E→W→L→N (bit 4 down to bit 0, wrapping). "Next requester" is the first masked-request bit strictly after the owner, wrapping back to and including the owner itself.
- Per output, priority-ordered update each cycle:
  - Served (`X_port_enable`=1): turn ← next requester. If none requests, turn holds.
  - Owner not requesting and another legal input requesting: turn ← next requester.
  - Timeout (macro only): owner requesting, unserved, wait count = `TIMEOUT`. Turn ← next requester excluding owner. If no other requester, holds and count stays saturated.
  - Otherwise: hold.
- Wait counter per output:
  - Clears on reset, on any turn change, and on served.
  - Increments when the owner requests and is unserved.
  - Saturates at `TIMEOUT`.
  - Width `$clog2(TIMEOUT+1)`.
- `X_turn` is always exactly one-hot and always a legal input for that port.
- Reset values: `N_turn`, `S_turn`, `E_turn`, `W_turn` = 5'b00001 (L). `L_turn` = 5'b10000 (N). All wait counters 0.

## Timing
- Turn change visible one cycle after the causing event, with no combinational path from `X_req` or `X_port_enable` to `X_turn`.
- Back-to-back serves rotate the owner every cycle.
- Served and timeout in the same cycle: served wins, and the counter clears.
- `rst` asserted mid-operation: next edge forces reset values regardless of requests.
- All requests 0: all turns hold indefinitely.

## Configuration
- `NOC_TURN_TIMEOUT_EN` defined: wait counters and forced rotation present; `TIMEOUT` effective.
- `NOC_TURN_TIMEOUT_EN` undefined: no counters. A requesting owner keeps the turn until served; `TIMEOUT` ignored.

## Structure
- Package `noc_pkg` holds:
  - port index constants (`PORT_N`=4 … `PORT_L`=0),
  - one-hot constants,
  - legal-turn masks `TURN_MASK_N/S/E/W/L`,
  - per-port reset turn values.
- Sub-module `noc_rr_pointer`: one instance per output port. It contains the turn register, the wrap-around next-requester search, and the optional wait counter. Mask and reset value are parameters. Top level is five instances plus wiring.

## Test plan
- Reset: assert `rst` 1 cycle with random requests → N/S/E/W_turn = 00001, L_turn = 10000.
- E output rotation: `E_req`=11011 and `E_port_enable`=1 for 4 cycles from reset → E_turn = 10000, 01000, 00010, 00001.
- Idle skip: `N_turn`=00001, `N_req`=01000, no serve → next cycle N_turn = 01000. Then `N_req`=00000 → holds 01000.
- Illegal mask: `S_req`=00110 (E, W only) for 10 cycles → S_turn stays 00001.
- Timeout (macro on, `TIMEOUT`=3): `W_turn`=00001, `W_req`=00101, no serve → W_turn = 00100 four cycles after the counter starts. With the macro off, W_turn stays 00001 for 50 cycles.
- Serve beats timeout: counter at 3, `W_port_enable`=1 the same cycle → single rotation to the next requester, counter 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared constants for the router turn scheduler: port indices, one-hot
// codes, legal-turn masks (Y-then-X routing) and per-output reset owners.
// The optional forced-rotation feature is controlled by NOC_TURN_TIMEOUT_EN.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam int PORT_N = 4;
  localparam int PORT_S = 3;
  localparam int PORT_E = 2;
  localparam int PORT_W = 1;
  localparam int PORT_L = 0;

  localparam logic [4:0] OH_N = 5'b10000;
  localparam logic [4:0] OH_S = 5'b01000;
  localparam logic [4:0] OH_E = 5'b00100;
  localparam logic [4:0] OH_W = 5'b00010;
  localparam logic [4:0] OH_L = 5'b00001;

  // Y-then-X: an X-travelling flit may never turn back into Y.
  localparam logic [4:0] TURN_MASK_N = OH_S | OH_L;
  localparam logic [4:0] TURN_MASK_S = OH_N | OH_L;
  localparam logic [4:0] TURN_MASK_E = OH_N | OH_S | OH_W | OH_L;
  localparam logic [4:0] TURN_MASK_W = OH_N | OH_S | OH_E | OH_L;
  localparam logic [4:0] TURN_MASK_L = OH_N | OH_S | OH_E | OH_W;

  localparam logic [4:0] RST_TURN_N = OH_L;
  localparam logic [4:0] RST_TURN_S = OH_L;
  localparam logic [4:0] RST_TURN_E = OH_L;
  localparam logic [4:0] RST_TURN_W = OH_L;
  localparam logic [4:0] RST_TURN_L = OH_N;

  // First candidate strictly after the owner in N->S->E->W->L order
  // (descending bit index, wrapping), with the owner itself tried last.
  // Returns zero when no candidate bit is set.
  function automatic logic [4:0] rr_next(input logic [4:0] owner,
                                         input logic [4:0] cand);
    logic [4:0] res;
    int         own_idx;
    logic [2:0] idx;
    res     = '0;
    own_idx = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner[3'(i)]) own_idx = i;
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = 3'((own_idx + NUM_PORTS - k) % NUM_PORTS);
      if (res == '0 && cand[idx]) res[idx] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_rr_pointer.sv
// Round-robin turn register for one router output. Holds the one-hot owner,
// rotates on serve or when the owner goes idle, and (with
// NOC_TURN_TIMEOUT_EN defined) forces rotation away from an owner that has
// waited TIMEOUT cycles without being served.
module noc_rr_pointer
  import noc_pkg::*;
#(
  parameter logic [4:0]  MASK     = 5'b11111,
  parameter logic [4:0]  RST_TURN = 5'b00001,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       port_enable,
  output logic [4:0] turn
);

  // A timeout of zero would rotate a requesting owner before it could wait.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("noc_rr_pointer: TIMEOUT must be at least 1");
  end

  logic [4:0] req_m;
  logic [4:0] nxt_any;
  logic       owner_req;

  assign req_m     = req & MASK;
  assign owner_req = |(req_m & turn);
  assign nxt_any   = rr_next(turn, req_m);

`ifdef NOC_TURN_TIMEOUT_EN
  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       nxt_other;

  assign nxt_other = rr_next(turn, req_m & ~turn);

  // Turn and wait counter update; serve outranks idle skip, which outranks timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn     <= RST_TURN;
      wait_cnt <= '0;
    end else if (port_enable) begin
      if (nxt_any != '0) turn <= nxt_any;
      wait_cnt <= '0;
    end else if (!owner_req && req_m != '0) begin
      turn     <= nxt_any;
      wait_cnt <= '0;
    end else if (owner_req && wait_cnt == CNT_MAX) begin
      // With no other requester the counter simply stays saturated.
      if (nxt_other != '0) begin
        turn     <= nxt_other;
        wait_cnt <= '0;
      end
    end else if (owner_req) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // Turn update; a requesting owner keeps the turn until served.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn <= RST_TURN;
    end else if (port_enable) begin
      if (nxt_any != '0) turn <= nxt_any;
    end else if (!owner_req && req_m != '0) begin
      turn <= nxt_any;
    end
  end
`endif

endmodule

// File: rtl/noc_turn_arbiter.sv
// Per-router turn scheduler: one round-robin pointer per output port, each
// producing a registered one-hot X_turn for the route logic.
// Optional forced rotation of stalled owners: NOC_TURN_TIMEOUT_EN.
module noc_turn_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] N_req,
  input  logic [4:0] S_req,
  input  logic [4:0] E_req,
  input  logic [4:0] W_req,
  input  logic [4:0] L_req,
  input  logic       N_port_enable,
  input  logic       S_port_enable,
  input  logic       E_port_enable,
  input  logic       W_port_enable,
  input  logic       L_port_enable,
  output logic [4:0] N_turn,
  output logic [4:0] S_turn,
  output logic [4:0] E_turn,
  output logic [4:0] W_turn,
  output logic [4:0] L_turn
);

  noc_rr_pointer #(.MASK(TURN_MASK_N), .RST_TURN(RST_TURN_N), .TIMEOUT(TIMEOUT)) u_n (
    .clk(clk), .rst(rst), .req(N_req), .port_enable(N_port_enable), .turn(N_turn)
  );

  noc_rr_pointer #(.MASK(TURN_MASK_S), .RST_TURN(RST_TURN_S), .TIMEOUT(TIMEOUT)) u_s (
    .clk(clk), .rst(rst), .req(S_req), .port_enable(S_port_enable), .turn(S_turn)
  );

  noc_rr_pointer #(.MASK(TURN_MASK_E), .RST_TURN(RST_TURN_E), .TIMEOUT(TIMEOUT)) u_e (
    .clk(clk), .rst(rst), .req(E_req), .port_enable(E_port_enable), .turn(E_turn)
  );

  noc_rr_pointer #(.MASK(TURN_MASK_W), .RST_TURN(RST_TURN_W), .TIMEOUT(TIMEOUT)) u_w (
    .clk(clk), .rst(rst), .req(W_req), .port_enable(W_port_enable), .turn(W_turn)
  );

  noc_rr_pointer #(.MASK(TURN_MASK_L), .RST_TURN(RST_TURN_L), .TIMEOUT(TIMEOUT)) u_l (
    .clk(clk), .rst(rst), .req(L_req), .port_enable(L_port_enable), .turn(L_turn)
  );

endmodule
